// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and helpers for the hazard / forwarding unit.
//   FWD_REG / FWD_WB / FWD_MEM : EX operand mux select encodings.
//   DEF_REG_AW                 : default register address width.
//   field_get()                : extract field <idx> of width <width> from a
//                                packed vector (field 0 in the LSBs).
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int DEF_REG_AW = 5;

  // Widest packed vector / field the helper handles; callers zero-extend
  // their vector to MAX_VEC_W and cast the result down to their field width.
  localparam int MAX_VEC_W   = 64;
  localparam int MAX_FIELD_W = 16;

  function automatic logic [MAX_FIELD_W-1:0] field_get(
    input logic [MAX_VEC_W-1:0] vec,
    input int unsigned          idx,
    input int unsigned          width
  );
    logic [MAX_VEC_W-1:0]   shifted;
    logic [MAX_FIELD_W-1:0] mask;
    shifted = vec >> (idx * width);
    mask    = ~({MAX_FIELD_W{1'b1}} << width);
    return shifted[MAX_FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-writeback bits for long-latency operations.
//   clk, rst          : clock, synchronous active-high reset.
//   mc_issue/mc_rd_addr : long-latency op leaves EX, marks its rd busy.
//   mc_done/mc_done_rd  : long-latency result written back, clears its rd.
//   sb_busy           : registered busy bit per architectural register.
//   sb_err            : sticky protocol error (double issue / orphan done).
module hazard_scoreboard #(
  parameter int REG_AW   = hazard_pkg::DEF_REG_AW,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mc_issue,
  input  logic [REG_AW-1:0]   mc_rd_addr,
  input  logic                mc_done,
  input  logic [REG_AW-1:0]   mc_done_rd,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic                sb_err
);
  import hazard_pkg::*;

  logic                issue_v;
  logic                done_v;
  logic                same_rd;
  logic                err_issue;
  logic                err_done;
  logic [NUM_REGS-1:0] busy_next;

  // x0 is never tracked: issues and dones naming x0 are both dropped.
  assign issue_v = mc_issue && (mc_rd_addr != '0);
  assign done_v  = mc_done  && (mc_done_rd != '0);
  assign same_rd = issue_v && done_v && (mc_rd_addr == mc_done_rd);

  // A re-issue to a busy rd is legal only when that rd's done lands in the
  // same cycle; a done for a rd that is not busy is an orphan and is ignored.
  assign err_issue = issue_v && sb_busy[mc_rd_addr] && !same_rd;
  assign err_done  = done_v && !sb_busy[mc_done_rd];

  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned and no latch is inferred.
    busy_next = sb_busy;
    if (done_v && sb_busy[mc_done_rd]) busy_next[mc_done_rd] = 1'b0;
    // Set is applied after clear, so a same-rd issue/done pair stays busy.
    if (issue_v) busy_next[mc_rd_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    if (rst) begin
      // Reset drops in-flight ops; their late dones are flagged as orphans.
      sb_busy <= '0;
      sb_err  <= 1'b0;
    end else begin
      sb_busy <= busy_next;
      if (err_issue || err_done) sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand forwarding selects, ID stall generation and
// long-latency scoreboard for a pipeline with NUM_SRC register sources.
//   clk, rst              : clock, synchronous active-high reset.
//   id_rs_addr/id_rs_used : ID sources (packed, source 0 in LSBs) + valid mask.
//   id_reg_wen/id_rd_addr : ID destination.
//   ex_rs_addr            : EX sources (packed) to be forwarded.
//   ex_reg_wen/ex_mem_read/ex_rd_addr : EX destination, load flag.
//   mem_*/wb_*            : MEM and WB stage writeback ports.
//   mc_issue/mc_rd_addr, mc_done/mc_done_rd : long-latency op tracking.
//   fwd_sel               : per-source 2-bit select (00 RF, 01 WB, 10 MEM).
//   stall_id              : hold IF/ID, bubble into EX.
//   sb_busy, sb_err       : scoreboard state and sticky protocol error.
//   stall_cycles          : saturating count of stalled cycles.
module hazard_fwd_unit #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = hazard_pkg::DEF_REG_AW,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      id_reg_wen,
  input  logic [REG_AW-1:0]         id_rd_addr,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_addr,
  input  logic                      ex_reg_wen,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         ex_rd_addr,
  input  logic                      mem_reg_wen,
  input  logic [REG_AW-1:0]         mem_rd_addr,
  input  logic                      wb_reg_wen,
  input  logic [REG_AW-1:0]         wb_rd_addr,
  input  logic                      mc_issue,
  input  logic [REG_AW-1:0]         mc_rd_addr,
  input  logic                      mc_done,
  input  logic [REG_AW-1:0]         mc_done_rd,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_id,
  output logic [NUM_REGS-1:0]       sb_busy,
  output logic                      sb_err,
  output logic [CNT_W-1:0]          stall_cycles
);
  import hazard_pkg::*;

  logic [MAX_VEC_W-1:0] id_rs_vec;
  logic [MAX_VEC_W-1:0] ex_rs_vec;
  logic                 mem_fwd_ok;
  logic                 wb_fwd_ok;
  logic                 load_use_ok;
  logic                 load_use_stall;
  logic                 raw_stall;
  logic                 waw_stall;

  assign id_rs_vec = MAX_VEC_W'(id_rs_addr);
  assign ex_rs_vec = MAX_VEC_W'(ex_rs_addr);

  // Stage-level qualifiers shared by every source; x0 is never forwarded.
  assign mem_fwd_ok  = mem_reg_wen && (mem_rd_addr != '0);
  assign wb_fwd_ok   = wb_reg_wen  && (wb_rd_addr  != '0);
  assign load_use_ok = ex_mem_read && ex_reg_wen && (ex_rd_addr != '0);

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .mc_issue   (mc_issue),
    .mc_rd_addr (mc_rd_addr),
    .mc_done    (mc_done),
    .mc_done_rd (mc_done_rd),
    .sb_busy    (sb_busy),
    .sb_err     (sb_err)
  );

  // Per-source forwarding select; MEM holds the younger result, so it wins.
  always_comb begin
    logic [REG_AW-1:0] ex_rs;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_rs = REG_AW'(field_get(ex_rs_vec, i, REG_AW));
      if (mem_fwd_ok && (mem_rd_addr == ex_rs))
        fwd_sel[2*i +: 2] = FWD_MEM;
      else if (wb_fwd_ok && (wb_rd_addr == ex_rs))
        fwd_sel[2*i +: 2] = FWD_WB;
      else
        fwd_sel[2*i +: 2] = FWD_REG;
    end
  end

  // Stall terms look at the registered sb_busy, so a done in this cycle
  // only releases the stall from the next cycle on.
  always_comb begin
    logic [REG_AW-1:0] id_rs;
    load_use_stall = 1'b0;
    raw_stall      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_rs = REG_AW'(field_get(id_rs_vec, i, REG_AW));
      if (load_use_ok && id_rs_used[i] && (id_rs == ex_rd_addr))
        load_use_stall = 1'b1;
      if (id_rs_used[i] && (id_rs != '0) && sb_busy[id_rs])
        raw_stall = 1'b1;
    end
  end

  assign waw_stall = id_reg_wen && (id_rd_addr != '0) && sb_busy[id_rd_addr];
  assign stall_id  = load_use_stall || raw_stall || waw_stall;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall_id && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
